// File: rtl/hex_display_scheduler.sv
// Six-digit display source scheduler: software value vs. last bus write address,
// with auto-rotate dwell, sw preemption and freeze. Optional macro HEX_SCHED_LZB_EN.
`timescale 1ns/1ps
module hex_display_scheduler #(
    parameter int unsigned DWELL_CYCLES = 25000000,
    parameter int unsigned DIGITS       = 6
) (
    input  logic                  SI_ClkIn,
    input  logic                  SI_Reset,
    input  logic [4*DIGITS-1:0]   sw_value,
    input  logic                  sw_valid,
    input  logic [31:0]           bus_addr,
    input  logic                  bus_write,
    input  logic [1:0]            mode,
    input  logic                  freeze,
    output logic [4*DIGITS-1:0]   digit_code,
    output logic [DIGITS-1:0]     digit_blank,
    output logic                  src_sel,
    output logic [7:0]            capture_cnt
);
    localparam int unsigned W = 4 * DIGITS;
    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

    typedef enum logic {SHOW_SW = 1'b0, SHOW_BUS = 1'b1} state_t;

    state_t              r_state, w_state_next;
    logic [31:0]         r_dwell, w_dwell_next;
    logic                w_fsm_bus;

    logic [W-1:0]        r_sw_shadow, r_bus_shadow;
    logic [7:0]          r_capture_cnt;
    logic [W-1:0]        r_digit_code;
    logic [DIGITS-1:0]   r_digit_blank;
    logic                r_src_sel;

    logic                w_src_next;
    logic [W-1:0]        w_sel_code;
    logic [DIGITS-1:0]   w_blank_next;
    logic                w_unused_addr_hi;

    assign w_unused_addr_hi = ^bus_addr[31:W];

    // Shadows: sw loads even while frozen; bus captures are dropped while frozen.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            r_sw_shadow   <= '0;
            r_bus_shadow  <= '0;
            r_capture_cnt <= '0;
        end else begin
            if (sw_valid)
                r_sw_shadow <= sw_value;
            if (bus_write && !freeze) begin
                r_bus_shadow  <= bus_addr[W-1:0];
                r_capture_cnt <= r_capture_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            r_state <= SHOW_SW;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_next;
            r_dwell <= w_dwell_next;
        end
    end

    // Freeze outranks everything; preemption outranks dwell expiry.
    always_comb begin
        w_state_next = r_state;
        w_dwell_next = r_dwell;
        if (freeze) begin
            w_state_next = r_state;
            w_dwell_next = r_dwell;
        end else if (mode != 2'd2) begin
            w_state_next = SHOW_SW;
            w_dwell_next = '0;
        end else if (sw_valid) begin
            w_state_next = SHOW_SW;
            w_dwell_next = '0;
        end else if (r_dwell == DWELL_LAST) begin
            w_state_next = (r_state == SHOW_SW) ? SHOW_BUS : SHOW_SW;
            w_dwell_next = '0;
        end else begin
            w_dwell_next = r_dwell + 32'd1;
        end
    end

    always_comb begin
        w_fsm_bus = (r_state == SHOW_BUS);
    end

    always_comb begin
        w_src_next = r_src_sel;
        case (mode)
            2'd0:    w_src_next = 1'b0;
            2'd1:    w_src_next = 1'b1;
            2'd2:    w_src_next = w_fsm_bus;
            default: w_src_next = r_src_sel;
        endcase
        w_sel_code = w_src_next ? r_bus_shadow : r_sw_shadow;
    end

`ifdef HEX_SCHED_LZB_EN
    logic [DIGITS-1:0] w_lzb;
    // Digit k is dark when it and every digit above it are zero; digit 0 always lit.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
        if (gi == 0) begin : g_lsd
            assign w_lzb[gi] = 1'b0;
        end else begin : g_upper
            assign w_lzb[gi] = ~|w_sel_code[W-1:4*gi];
        end
    end
    assign w_blank_next = (mode == 2'd3) ? '1 : w_lzb;
`else
    assign w_blank_next = (mode == 2'd3) ? '1 : '0;
`endif

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            r_digit_code  <= '0;
            r_digit_blank <= '1;
            r_src_sel     <= 1'b0;
        end else if (!freeze) begin
            if (mode != 2'd3)
                r_digit_code <= w_sel_code;
            r_digit_blank <= w_blank_next;
            r_src_sel     <= w_src_next;
        end
    end

    assign digit_code  = r_digit_code;
    assign digit_blank = r_digit_blank;
    assign src_sel     = r_src_sel;
    assign capture_cnt = r_capture_cnt;
endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler with DWELL_CYCLES=8.
`timescale 1ns/1ps
module tb_hex_display_scheduler;
    localparam int unsigned DW = 8;

`ifdef HEX_SCHED_LZB_EN
    localparam logic [5:0] BLK_450 = 6'b111000;
    localparam logic [5:0] BLK_0   = 6'b111110;
`else
    localparam logic [5:0] BLK_450 = 6'b000000;
    localparam logic [5:0] BLK_0   = 6'b000000;
`endif

    logic        clk = 1'b0;
    logic        srst;
    logic [23:0] sw_value;
    logic        sw_valid;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic [1:0]  mode;
    logic        freeze;
    logic [23:0] digit_code;
    logic [5:0]  digit_blank;
    logic        src_sel;
    logic [7:0]  capture_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hex_display_scheduler #(.DWELL_CYCLES(DW), .DIGITS(6)) dut (
        .SI_ClkIn    (clk),
        .SI_Reset    (srst),
        .sw_value    (sw_value),
        .sw_valid    (sw_valid),
        .bus_addr    (bus_addr),
        .bus_write   (bus_write),
        .mode        (mode),
        .freeze      (freeze),
        .digit_code  (digit_code),
        .digit_blank (digit_blank),
        .src_sel     (src_sel),
        .capture_cnt (capture_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        srst = 1'b1; sw_value = '0; sw_valid = 1'b0; bus_addr = '0;
        bus_write = 1'b0; mode = 2'd0; freeze = 1'b0;
        tick(2);
        check("rst_code",  32'(digit_code),  32'h0);
        check("rst_blank", 32'(digit_blank), 32'h3F);
        check("rst_src",   32'(src_sel),     32'h0);
        check("rst_cnt",   32'(capture_cnt), 32'h0);
        srst = 1'b0;

        // Software path latency
        sw_value = 24'h123456; sw_valid = 1'b1;
        tick(1);
        sw_valid = 1'b0;
        check("sw_lat_n1", 32'(digit_code), 32'h0);
        tick(1);
        check("sw_code",  32'(digit_code),  32'h123456);
        check("sw_src",   32'(src_sel),     32'h0);
        check("sw_blank", 32'(digit_blank), 32'h0);

        // Bus trace captures
        mode = 2'd1; bus_write = 1'b1;
        bus_addr = 32'hBFC0_0010; tick(1);
        bus_addr = 32'h8000_0004; tick(1);
        bus_addr = 32'h1F80_0008; tick(1);
        bus_write = 1'b0;
        check("bus_cnt3", 32'(capture_cnt), 32'd3);
        check("bus_lat",  32'(digit_code),  32'h000004);
        tick(1);
        check("bus_code", 32'(digit_code),  32'h800008);
        check("bus_src",  32'(src_sel),     32'h1);
        check("bus_blank",32'(digit_blank), 32'h0);

        // Auto-rotate from entry
        mode = 2'd2;
        tick(8);  check("rot_e7_sw",   32'(src_sel), 32'h0);
        tick(1);  check("rot_e8_bus",  32'(src_sel), 32'h1);
                  check("rot_e8_code", 32'(digit_code), 32'h800008);
        tick(7);  check("rot_e15_bus", 32'(src_sel), 32'h1);
        tick(1);  check("rot_e16_sw",  32'(src_sel), 32'h0);
        tick(8);  check("rot_e24_bus", 32'(src_sel), 32'h1);

        // Preemption during SHOW_BUS
        sw_value = 24'h000450; sw_valid = 1'b1;
        tick(1);
        sw_valid = 1'b0;
        check("pre_e25_bus", 32'(src_sel), 32'h1);
        tick(1);
        check("pre_e26_sw",  32'(src_sel),     32'h0);
        check("pre_code",    32'(digit_code),  32'h000450);
        check("pre_blank",   32'(digit_blank), 32'(BLK_450));
        tick(7);  check("pre_e33_sw",  32'(src_sel), 32'h0);
        tick(1);  check("pre_e34_bus", 32'(src_sel), 32'h1);

        // Preemption coincident with expiry in SHOW_SW
        tick(14);
        sw_value = 24'h000000; sw_valid = 1'b1;
        tick(1);
        sw_valid = 1'b0;
        check("tie_e49_sw", 32'(src_sel), 32'h0);
        tick(1);
        check("tie_e50_sw",  32'(src_sel),     32'h0);
        check("tie_code",    32'(digit_code),  32'h0);
        check("tie_blank",   32'(digit_blank), 32'(BLK_0));

        // Freeze with bus activity
        freeze = 1'b1; bus_addr = 32'h00AB_CDEF;
        for (int i = 0; i < 20; i++) begin
            bus_write = (i % 2 == 0);
            tick(1);
        end
        check("frz_code",  32'(digit_code),  32'h0);
        check("frz_src",   32'(src_sel),     32'h0);
        check("frz_cnt",   32'(capture_cnt), 32'd3);
        check("frz_blank", 32'(digit_blank), 32'(BLK_0));
        freeze = 1'b0; bus_write = 1'b0;
        tick(7);  check("rel_e77_sw",  32'(src_sel), 32'h0);
        tick(1);  check("rel_e78_bus", 32'(src_sel), 32'h1);
                  check("rel_code",    32'(digit_code), 32'h800008);

        // Blank mode
        mode = 2'd3;
        tick(1);
        check("m3_blank", 32'(digit_blank), 32'h3F);
        check("m3_code",  32'(digit_code),  32'h800008);

        // Capture counter wrap
        mode = 2'd1; bus_write = 1'b1;
        for (int i = 0; i < 253; i++) begin
            bus_addr = 32'(i);
            tick(1);
        end
        bus_write = 1'b0;
        check("wrap_cnt0", 32'(capture_cnt), 32'd0);
        bus_addr = 32'hFFF0_0D01; bus_write = 1'b1;
        tick(1);
        bus_write = 1'b0;
        check("wrap_cnt1", 32'(capture_cnt), 32'd1);
        tick(1);
        check("wrap_code", 32'(digit_code), 32'hF00D01);
        check("wrap_src",  32'(src_sel),    32'h1);

        // Reset mid-dwell while frozen and strobing
        mode = 2'd2;
        tick(3);
        srst = 1'b1; freeze = 1'b1; sw_valid = 1'b1; sw_value = 24'hABCDEF;
        bus_write = 1'b1;
        tick(1);
        check("mrst_code",  32'(digit_code),  32'h0);
        check("mrst_blank", 32'(digit_blank), 32'h3F);
        check("mrst_src",   32'(src_sel),     32'h0);
        check("mrst_cnt",   32'(capture_cnt), 32'h0);
        srst = 1'b0; freeze = 1'b0; sw_valid = 1'b0; bus_write = 1'b0;
        tick(8);  check("mrst_e7_sw",  32'(src_sel), 32'h0);
        tick(1);  check("mrst_e8_bus", 32'(src_sel), 32'h1);
                  check("mrst_code_bus", 32'(digit_code),  32'h0);
                  check("mrst_blank_bus",32'(digit_blank), 32'(BLK_0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hex_display_scheduler.md
# hex_display_scheduler

Sequences the six on-board seven-segment digits between two requesters: the software-written display value (memory-mapped LED/display register) and a bus-trace snapshot of the last AHB write address. It sits between `mfp_system` and the per-digit `single_digit_display` decoders in the board top. It drives one nibble plus a blank flag per digit, chosen by a mode input and an auto-rotate state machine with dwell timing, preemption and freeze.

## Interface
Parameters:
- `DWELL_CYCLES`, 25000000: auto-rotate dwell per source, in clocks (0.5 s at 50 MHz); legal range 2 to 2^32-1.
- `DIGITS`, 6: number of digits; fixed at 6 for this revision.

Ports:
- `SI_ClkIn` in 1: the block's single clock.
- `SI_Reset` in 1: synchronous, active-high reset.
- `sw_value` in 24: software display value; nibble k goes to digit k.
- `sw_valid` in 1: one-cycle strobe; `sw_value` is new this cycle.
- `bus_addr` in 32: HADDR.
- `bus_write` in 1: HWRITE qualified as an active write address phase.
- `mode` in 2: 0 software only, 1 bus trace only, 2 auto-rotate, 3 blank.
- `freeze` in 1: level; holds the displayed content.
- `digit_code` out 24: registered nibbles to the decoders.
- `digit_blank` out 6: registered; 1 forces digit k dark in the top level.
- `src_sel` out 1: registered; 0 software, 1 bus.
- `capture_cnt` out 8: registered count of bus captures; wraps 255 to 0.

## Operation
- Shadow registers:
  - `sw_shadow` loads `sw_value` on `sw_valid`, including while frozen.
  - `bus_shadow` loads `bus_addr[23:0]` on `bus_write` when `freeze`=0. Each such load increments `capture_cnt`. While frozen, captures are ignored and `capture_cnt` holds.
- Auto-rotate FSM (active in mode 2), states SHOW_SW and SHOW_BUS:
  - The dwell counter counts up each cycle.
  - When it reaches `DWELL_CYCLES-1`, the FSM toggles state and the counter clears.
  - A `sw_valid` strobe preempts: the FSM forces SHOW_SW and clears the counter, whatever the current state or count.
  - A `sw_valid` arriving in the same cycle as dwell expiry: preemption wins, and the state is SHOW_SW.
- Outside mode 2:
  - The FSM is held in SHOW_SW and the counter is held at 0.
  - Entering mode 2 therefore always starts in SHOW_SW with a full dwell.
- Output selection:
  - Mode 0: `sw_shadow`, `src_sel`=0.
  - Mode 1: `bus_shadow`, `src_sel`=1.
  - Mode 2: the FSM state selects the source.
  - Mode 3: `digit_code` holds its last value and `digit_blank`=6'h3F.
  - In modes 0–2, `digit_blank`=0 unless leading-zero blanking is enabled (see Configuration).
- Freeze:
  - Output registers, FSM state and dwell counter all hold.
  - On release, the next cycle reflects the current mode and shadows.
- Reset values:
  - `digit_code`=0, `digit_blank`=6'h3F, `src_sel`=0, `capture_cnt`=0.
  - Both shadows 0, FSM in SHOW_SW, dwell counter 0.

## Timing
- Outputs are registered: one-cycle latency from the shadow-register update to `digit_code`.
  - Timeline: `sw_valid` at cycle N; shadow updated at N+1; outputs show the new value at N+2.
  - `bus_write` follows the same N/N+1/N+2 timeline.
- Dwell: with no preemption, the first SHOW_BUS appears on the outputs `DWELL_CYCLES`+1 cycles after mode 2 is entered.
- A mode change takes effect on the outputs one cycle after `mode` is sampled.
- Reset asserted mid-dwell or mid-freeze restores all reset values on the next edge, regardless of other inputs.
- `capture_cnt` updates in the same cycle as `bus_shadow`.

## Configuration
- `HEX_SCHED_LZB_EN` defined:
  - Leading-zero blanking applies in modes 0–2.
  - Digit k is blanked when it and every higher digit are zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Blank flags are computed from the selected source and registered together with `digit_code`.
- Macro undefined: `digit_blank` is 0 in modes 0–2, and all six digits are always lit.

## Test plan
- Reset, then mode=0 and `sw_valid` with `sw_value`=24'h123456 → two cycles later `digit_code`=24'h123456, `src_sel`=0, `digit_blank`=0.
- Mode=1, three `bus_write` pulses with `bus_addr`=32'hBFC0_0010, 32'h8000_0004, 32'h1F80_0008 → `digit_code`=24'h800008, `capture_cnt`=3.
- Mode=2, `DWELL_CYCLES`=8, no `sw_valid` → `src_sel` toggles every 8 cycles, first 1 at cycle 9 after entry. A `sw_valid` during SHOW_BUS → `src_sel`=0 one cycle after the shadow update, and the next toggle is 8 cycles later.
- `sw_valid` on the same cycle as dwell expiry → state stays SHOW_SW. Then `freeze`=1 for 20 cycles with `bus_write` pulses → outputs and `capture_cnt` unchanged; after release the dwell resumes from its held count.
- With `HEX_SCHED_LZB_EN` defined, `sw_value`=24'h000450 → `digit_blank`=6'b111000. With `sw_value`=0 → `digit_blank`=6'b111110. Mode=3 → `digit_blank`=6'h3F.
- 256 bus captures → `capture_cnt` wraps to 0. Assert `SI_Reset` mid-dwell → all outputs return to reset values next edge.
